pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, redirects, traps and a circular
// return-address stack that predicts the target of return instructions.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_out_ready,
  input  logic                         trap,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign,
  output logic                         ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_m1;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    top_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] pc_next;
  logic             pop;
  logic             push;
  logic             underflow_next;
  logic             misalign_next;
  logic             advance;

  assign pc_plus4 = pc + WIDTH'(4);
  assign top_m1   = top - PW'(1);
  assign advance  = rst && !trap && mem_out_ready;

  always_comb begin
    pop            = ret && (ras_count != '0);
    push           = call;
    underflow_next = ret && (ras_count == '0);
    misalign_next  = redirect && (redirect_pc[1:0] != 2'b00);
    top_next       = top;
    count_next     = ras_count;
    wr_idx         = top;
    pc_next        = pc_plus4;

    if (redirect) begin
      pc_next = misalign_next ? TRAP_VECTOR : redirect_pc;
    end else if (pop) begin
      pc_next = ras[top_m1];
    end

    // A same-cycle pop and push reuse the freed slot, leaving depth unchanged.
    if (pop && push) begin
      wr_idx = top_m1;
    end else if (pop) begin
      top_next   = top_m1;
      count_next = ras_count - CW'(1);
    end else if (push) begin
      top_next   = top + PW'(1);
      count_next = (ras_count == DEPTH_C) ? ras_count : ras_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= RESET_VECTOR;
      ras_count     <= '0;
      top           <= '0;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (trap) begin
      pc            <= TRAP_VECTOR;
      ras_count     <= '0;
      top           <= '0;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!mem_out_ready) begin
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      ras_count     <= count_next;
      top           <= top_next;
      misalign      <= misalign_next;
      ras_underflow <= underflow_next;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by ras_count alone.
  always_ff @(posedge clk) begin
    if (advance && push) begin
      ras[wr_idx] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_out_ready;
  logic        trap;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  ras_count;
  logic        misalign;
  logic        ras_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_mis;
  logic        m_und;

  pc_sequencer #(.WIDTH(WIDTH), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_out_ready(mem_out_ready), .trap(trap),
    .redirect(redirect), .redirect_pc(redirect_pc), .call(call), .ret(ret),
    .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count),
    .misalign(misalign), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [31:0] np;
    logic [31:0] ra;
    if (!rst) begin
      m_pc = RV; m_stack.delete(); m_mis = 0; m_und = 0;
    end else if (trap) begin
      m_pc = TV; m_stack.delete(); m_mis = 0; m_und = 0;
    end else if (!mem_out_ready) begin
      m_mis = 0; m_und = 0;
    end else begin
      np = m_pc + 32'd4; m_mis = 0; m_und = 0;
      if (ret) begin
        if (m_stack.size() > 0) begin
          ra = m_stack.pop_back();
          if (!redirect) np = ra;
        end else m_und = 1;
      end
      if (redirect) begin
        if (redirect_pc[1:0] == 2'b00) np = redirect_pc;
        else begin np = TV; m_mis = 1; end
      end
      if (call) begin
        m_stack.push_back(m_pc + 32'd4);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
      end
      m_pc = np;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1; mem_out_ready = 1; trap = 0; redirect = 0; redirect_pc = '0; call = 0; ret = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 0; tick(); rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; trap = 1; call = 1; redirect = 1; redirect_pc = 32'h40;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== RV) $display("FAIL reset_pc actual=%h expected=%h", pc, RV); else n_pass++;
    n_checks++;
    if (ras_count !== 3'd0 || misalign !== 1'b0 || ras_underflow !== 1'b0)
      $display("FAIL reset_ctrl actual=%0d/%b/%b expected=0/0/0", ras_count, misalign, ras_underflow);
    else n_pass++;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'(4 * i) || ras_count !== 3'd0)
        $display("FAIL seq_%0d actual=%h/%0d expected=%h/0", i, pc, ras_count, 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    idle_inputs(); redirect = 1; redirect_pc = 32'h20; tick();
    mem_out_ready = 0; redirect_pc = 32'h400; call = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h20 || ras_count !== 3'd0 || misalign !== 1'b0)
        $display("FAIL stall_%0d actual=%h/%0d/%b expected=20/0/0", i, pc, ras_count, misalign);
      else n_pass++;
    end
    idle_inputs(); tick();
    n_checks++;
    if (pc !== 32'h24) $display("FAIL stall_resume actual=%h expected=24", pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    do_reset();
    redirect = 1; redirect_pc = 32'h10; tick();
    call = 1; redirect_pc = 32'h200; tick();
    n_checks++;
    if (pc !== 32'h200 || ras_count !== 3'd1)
      $display("FAIL call_jump actual=%h/%0d expected=200/1", pc, ras_count);
    else n_pass++;
    idle_inputs(); tick();
    ret = 1; tick(); ret = 0;
    n_checks++;
    if (pc !== 32'h14 || ras_count !== 3'd0)
      $display("FAIL ret_target actual=%h/%0d expected=14/0", pc, ras_count);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      call = 1; redirect = 1; redirect_pc = 32'((i + 1) * 32'h100); tick();
      n_checks++;
      if (pc !== 32'((i + 1) * 32'h100) || ras_count !== 3'((i < 4) ? i + 1 : 4))
        $display("FAIL ovf_call_%0d actual=%h/%0d", i, pc, ras_count);
      else n_pass++;
    end
    idle_inputs(); ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'(32'h404 - i * 32'h100) || ras_count !== 3'(3 - i) || ras_underflow !== 1'b0)
        $display("FAIL ovf_ret_%0d actual=%h/%0d expected=%h/%0d", i, pc, ras_count,
                 32'(32'h404 - i * 32'h100), 3 - i);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (pc !== 32'h108 || ras_underflow !== 1'b1 || ras_count !== 3'd0)
      $display("FAIL ovf_underflow actual=%h/%b/%0d expected=108/1/0", pc, ras_underflow, ras_count);
    else n_pass++;
    ret = 0; tick();
    n_checks++;
    if (ras_underflow !== 1'b0) $display("FAIL underflow_pulse actual=%b expected=0", ras_underflow);
    else n_pass++;
  endtask

  task automatic test_misalign_trap();
    idle_inputs(); redirect = 1; redirect_pc = 32'h202; tick();
    n_checks++;
    if (pc !== TV || misalign !== 1'b1) $display("FAIL misalign actual=%h/%b expected=100/1", pc, misalign);
    else n_pass++;
    idle_inputs(); call = 1; tick(); call = 0;
    n_checks++;
    if (misalign !== 1'b0 || pc !== 32'h104 || ras_count !== 3'd1)
      $display("FAIL misalign_pulse actual=%h/%b/%0d expected=104/0/1", pc, misalign, ras_count);
    else n_pass++;
    mem_out_ready = 0; trap = 1; tick();
    idle_inputs();
    n_checks++;
    if (pc !== TV || ras_count !== 3'd0) $display("FAIL trap_stall actual=%h/%0d expected=100/0", pc, ras_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    idle_inputs(); redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick();
    redirect = 0; tick();
    n_checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4) $display("FAIL wrap actual=%h/%h expected=0/4", pc, pc_plus4);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    call = 1; ret = 1; tick(); call = 0; ret = 0;
    n_checks++;
    if (ras_underflow !== 1'b1 || ras_count !== 3'd1 || pc !== 32'h4)
      $display("FAIL callret_empty actual=%b/%0d/%h expected=1/1/4", ras_underflow, ras_count, pc);
    else n_pass++;
    tick(); call = 1; ret = 1; tick(); call = 0; ret = 0;
    n_checks++;
    if (pc !== 32'h4 || ras_count !== 3'd1)
      $display("FAIL callret_swap actual=%h/%0d expected=4/1", pc, ras_count);
    else n_pass++;
    ret = 1; tick(); ret = 0;
    n_checks++;
    if (pc !== 32'hC || ras_count !== 3'd0)
      $display("FAIL callret_pop actual=%h/%0d expected=c/0", pc, ras_count);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) >= 2);
      mem_out_ready = ($urandom_range(99) < 80);
      trap          = ($urandom_range(99) < 3);
      redirect      = ($urandom_range(99) < 20);
      redirect_pc   = $urandom & 32'h0000_FFFC;
      if ($urandom_range(9) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
      call          = ($urandom_range(99) < 25);
      ret           = ($urandom_range(99) < 25);
      tick();
      n_checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || ras_count !== 3'(m_stack.size()) ||
          misalign !== m_mis || ras_underflow !== m_und)
        $display("FAIL rand_%0d actual=%h/%0d/%b/%b expected=%h/%0d/%b/%b", i, pc, ras_count,
                 misalign, ras_underflow, m_pc, m_stack.size(), m_mis, m_und);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    m_pc = RV; m_mis = 0; m_und = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_call_ret();
    test_ras_overflow();
    test_misalign_trap();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
